// File: rtl/instruction_encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: formats, error codes,
// opcode constants and the encoder FSM state type.
package instruction_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_FORMAT = 2'd1;
  localparam logic [1:0] ERR_IMM    = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational RV32I field packer with immediate range/alignment check.
// Bad format wins over an immediate error; unused fields are ignored.
module instruction_field_packer
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  i_format,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic [1:0]  o_err_code
);

  logic w_is_ok;
  logic w_b_ok;
  logic w_j_ok;
  logic w_u_ok;

  // Sign-extension checks: upper bits must be a pure copy of the sign bit
  assign w_is_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_b_ok  = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
  assign w_j_ok  = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
  assign w_u_ok  = ~(|i_imm[11:0]);

  always_comb begin
    o_word     = '0;
    o_err_code = ERR_NONE;
    case (i_format)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: begin
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (!w_is_ok) o_err_code = ERR_IMM;
      end
      FMT_S: begin
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        if (!w_is_ok) o_err_code = ERR_IMM;
      end
      FMT_B: begin
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], i_opcode};
        if (!w_b_ok) o_err_code = ERR_IMM;
      end
      FMT_U: begin
        o_word = {i_imm[31:12], i_rd, i_opcode};
        if (!w_u_ok) o_err_code = ERR_IMM;
      end
      FMT_J: begin
        o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        if (!w_j_ok) o_err_code = ERR_IMM;
      end
      default: o_err_code = ERR_FORMAT;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts RV32I field bundles, encodes them and writes each word to instruction
// memory at an auto-incrementing address; 3 cycles per instruction, waits on i_mem_ready.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_format,
  input  logic [6:0]            i_req_opcode,
  input  logic [2:0]            i_req_funct3,
  input  logic [6:0]            i_req_funct7,
  input  logic [4:0]            i_req_rd,
  input  logic [4:0]            i_req_rs1,
  input  logic [4:0]            i_req_rs2,
  input  logic [31:0]           i_req_imm,
  input  logic                  i_org_valid,
  input  logic [ADDR_WIDTH-1:0] i_org_addr,
  output logic                  o_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_write_data,
  input  logic                  i_mem_ready,
  output logic                  o_err_valid,
  output logic [1:0]            o_err_code,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam logic [ADDR_WIDTH:0] LP_CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                r_state;
  state_e                w_state_nxt;
  logic [2:0]            r_format;
  logic [6:0]            r_opcode;
  logic [2:0]            r_funct3;
  logic [6:0]            r_funct7;
  logic [4:0]            r_rd;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [31:0]           r_imm;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [31:0]           r_mem_data;
  logic                  r_err_vld;
  logic [1:0]            r_err_code;
  logic [31:0]           w_word;
  logic [1:0]            w_err_code;

  instruction_field_packer u_packer (
    .i_format   (r_format),
    .i_opcode   (r_opcode),
    .i_funct3   (r_funct3),
    .i_funct7   (r_funct7),
    .i_rd       (r_rd),
    .i_rs1      (r_rs1),
    .i_rs2      (r_rs2),
    .i_imm      (r_imm),
    .o_word     (w_word),
    .o_err_code (w_err_code)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_req_valid) w_state_nxt = ST_ENCODE;
      ST_ENCODE: w_state_nxt = (w_err_code != ERR_NONE) ? ST_IDLE : ST_WRITE;
      ST_WRITE:  if (i_mem_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decode from state so reset clears them without a clock edge
  always_comb begin
    o_req_ready        = (r_state == ST_IDLE);
    o_mem_write_enable = (r_state == ST_WRITE);
    o_mem_addr         = r_ptr;
    o_mem_write_data   = r_mem_data;
    o_err_valid        = r_err_vld;
    o_err_code         = r_err_vld ? r_err_code : ERR_NONE;
    o_count            = r_count;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_format   <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_ptr      <= ADDR_WIDTH'(BASE_ADDR);
      r_count    <= '0;
      r_mem_data <= '0;
      r_err_vld  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_err_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_org_valid) r_ptr <= i_org_addr;
          if (i_req_valid) begin
            r_format <= i_req_format;
            r_opcode <= i_req_opcode;
            r_funct3 <= i_req_funct3;
            r_funct7 <= i_req_funct7;
            r_rd     <= i_req_rd;
            r_rs1    <= i_req_rs1;
            r_rs2    <= i_req_rs2;
            r_imm    <= i_req_imm;
          end
        end
        ST_ENCODE: begin
          if (w_err_code != ERR_NONE) begin
            r_err_vld  <= 1'b1;
            r_err_code <= w_err_code;
          end else begin
            r_mem_data <= w_word;
          end
        end
        ST_WRITE: begin
          if (i_mem_ready) begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
            if (r_count != LP_CNT_MAX) r_count <= r_count + (ADDR_WIDTH + 1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with hand-computed encodings.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_format;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        org_valid;
  logic [9:0]  org_addr;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [10:0] count;

  int checks   = 0;
  int failures = 0;

  instruction_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_format       (req_format),
    .i_req_opcode       (req_opcode),
    .i_req_funct3       (req_funct3),
    .i_req_funct7       (req_funct7),
    .i_req_rd           (req_rd),
    .i_req_rs1          (req_rs1),
    .i_req_rs2          (req_rs2),
    .i_req_imm          (req_imm),
    .i_org_valid        (org_valid),
    .i_org_addr         (org_addr),
    .o_mem_write_enable (mem_we),
    .o_mem_addr         (mem_addr),
    .o_mem_write_data   (mem_data),
    .i_mem_ready        (mem_ready),
    .o_err_valid        (err_valid),
    .o_err_code         (err_code),
    .o_count            (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the ENCODE cycle.
  task automatic do_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check_eq("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    req_format = fmt; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // mem_ready is high: write visible one cycle after ENCODE, done the next edge.
  task automatic expect_write(input string tag, input logic [9:0] addr,
                              input logic [31:0] data, input logic [10:0] cnt);
    @(negedge clk);
    check_eq({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    check_eq({tag, "_addr"}, {22'd0, mem_addr}, {22'd0, addr});
    check_eq({tag, "_data"}, mem_data, data);
    @(negedge clk);
    check_eq({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    check_eq({tag, "_count"}, {21'd0, count}, {21'd0, cnt});
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code, input logic [9:0] addr);
    @(negedge clk);
    check_eq({tag, "_err_valid"}, {31'd0, err_valid}, 32'd1);
    check_eq({tag, "_err_code"}, {30'd0, err_code}, {30'd0, code});
    check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check_eq({tag, "_no_we"}, {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_err_clear"}, {29'd0, err_valid, err_code}, 32'd0);
    check_eq({tag, "_ptr_kept"}, {22'd0, mem_addr}, {22'd0, addr});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_format = '0; req_opcode = '0; req_funct3 = '0;
    req_funct7 = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    org_valid = 1'b0; org_addr = '0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_addr", {22'd0, mem_addr}, 32'd0);
    check_eq("rst_data", mem_data, 32'd0);
    check_eq("rst_err", {29'd0, err_valid, err_code}, 32'd0);
    check_eq("rst_count", {21'd0, count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // add x3,x1,x2
    do_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    check_eq("add_encode_no_we", {31'd0, mem_we}, 32'd0);
    expect_write("add", 10'd0, 32'h002081B3, 11'd1);
    // addi x5,x0,-1
    do_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_write("addi", 10'd1, 32'hFFF00293, 11'd2);
    // beq x1,x2,+8
    do_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_write("beq", 10'd2, 32'h00208463, 11'd3);
    do_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    expect_err("beq_odd", 2'd2, 10'd3);
    do_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001);
    expect_err("lui_low", 2'd2, 10'd3);
    do_req(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'h00000001);
    expect_err("fmt7", 2'd1, 10'd3);
    do_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
    expect_err("addi_range", 2'd2, 10'd3);
    check_eq("count_after_errs", {21'd0, count}, 32'd3);
    // sw x2,12(x1); jal x1,+2048; lui x5,0x12345
    do_req(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd12);
    expect_write("sw", 10'd3, 32'h0020A623, 11'd4);
    do_req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
    expect_write("jal", 10'd4, 32'h001000EF, 11'd5);
    do_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    expect_write("lui", 10'd5, 32'h123452B7, 11'd6);

    // Backpressure: mem_ready low for 5 WRITE cycles
    mem_ready = 1'b0;
    do_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_we", {31'd0, mem_we}, 32'd1);
      check_eq("bp_addr", {22'd0, mem_addr}, 32'd6);
      check_eq("bp_data", mem_data, 32'h002081B3);
      check_eq("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_done_ready", {31'd0, req_ready}, 32'd1);
    check_eq("bp_done_ptr", {22'd0, mem_addr}, 32'd7);
    check_eq("bp_done_count", {21'd0, count}, 32'd7);

    // Wrap from the top of the address space
    org_valid = 1'b1; org_addr = 10'd1023;
    @(negedge clk);
    org_valid = 1'b0; org_addr = 10'd0;
    do_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_write("wrap_hi", 10'd1023, 32'hFFF00293, 11'd8);
    do_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_write("wrap_lo", 10'd0, 32'hFFF00293, 11'd9);

    // Reset during WRITE clears outputs without a clock edge
    mem_ready = 1'b0;
    do_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    check_eq("pre_rst_we", {31'd0, mem_we}, 32'd1);
    check_eq("pre_rst_addr", {22'd0, mem_addr}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_we", {31'd0, mem_we}, 32'd0);
    check_eq("async_rst_addr", {22'd0, mem_addr}, 32'd0);
    check_eq("async_rst_count", {21'd0, count}, 32'd0);
    check_eq("async_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
